// File: rtl/udiv_20by4_seq.sv
// udiv_20by4_seq: sequential restoring divider, 20-bit dividend by 4-bit divisor.
// One quotient bit is resolved per clock, MSB first, so a division takes DVD_W
// cycles in BUSY and is followed by a single DONE cycle. The dividend shift
// register doubles as the quotient accumulator: each quotient bit drops into
// the LSB position vacated by the dividend bit just consumed.
module udiv_20by4_seq #(
    parameter int DVD_W = 20,
    parameter int DVS_W = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DVD_W-1:0] dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [DVD_W-1:0] quotient,
    output logic [DVS_W-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DVD_W-1:0]   dvd_q, dvd_d;       // dividend bits (top) / quotient bits (bottom)
    logic [DVS_W-1:0]   dvs_q, dvs_d;
    logic [DVS_W-1:0]   prem_q, prem_d;     // partial remainder
    logic [DVD_W-1:0]   quotient_q, quotient_d;
    logic [DVS_W-1:0]   remainder_q, remainder_d;
    logic               div_zero_q, div_zero_d;

    // Single restoring step on the current partial remainder
    logic [DVS_W:0]     pr;
    logic               qbit;
    logic [DVS_W-1:0]   prem_next;
    logic [DVD_W-1:0]   dvd_next;
    logic               last_iter;
    logic               accept;

    // One iteration: trial-subtract the divisor from {partial_rem, next dividend bit}.
    // When the subtraction succeeds the true difference is below the divisor,
    // so the low DVS_W bits of a modular subtraction are exact.
    always_comb begin
        pr        = {prem_q, dvd_q[DVD_W-1]};
        qbit      = (pr >= {1'b0, dvs_q});
        prem_next = qbit ? (pr[DVS_W-1:0] - dvs_q) : pr[DVS_W-1:0];
        dvd_next  = {dvd_q[DVD_W-2:0], qbit};
        last_iter = (cnt_q == CNT_W'(DVD_W - 1));
        accept    = start && (state_q != S_BUSY);
    end

    // Next-state and datapath control; operands are only captured on acceptance
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        prem_d      = prem_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;

        case (state_q)
            S_BUSY: begin
                dvd_d  = dvd_next;
                prem_d = prem_next;
                cnt_d  = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    state_d     = S_DONE;
                    quotient_d  = dvd_next;
                    remainder_d = prem_next;
                    div_zero_d  = (dvs_q == '0);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            state_d = S_BUSY;
            dvd_d   = dividend;
            dvs_d   = divisor;
            prem_d  = '0;
            cnt_d   = '0;
        end
    end

    // State and datapath registers, cleared immediately by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            prem_q      <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            prem_q      <= prem_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign done      = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_udiv_20by4_seq.sv
// tb_udiv_20by4_seq: directed checks of the sequential 20/4 divider.
module tb_udiv_20by4_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] dividend;
    logic [3:0]  divisor;
    logic        busy;
    logic        done;
    logic [19:0] quotient;
    logic [3:0]  remainder;
    logic        div_zero;

    int n_tests;
    int n_fail;

    logic [19:0] prev_q;
    logic [3:0]  prev_r;
    logic        prev_z;

    udiv_20by4_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Count falling edges until done is seen (bounded); returns the count
    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // One complete division with start pulsed for a single cycle
    task automatic run_div(input string tag, input logic [19:0] a, input logic [3:0] b,
                           input logic [19:0] eq, input logic [3:0] er, input logic ez);
        int n;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 20'($urandom);
        divisor  = 4'($urandom);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_hold_q"}, 32'(quotient), 32'(prev_q));
        wait_done(tag, n);
        check({tag, "_lat"}, 32'(n + 1), 32'd21);
        check({tag, "_q"}, 32'(quotient), 32'(eq));
        check({tag, "_r"}, 32'(remainder), 32'(er));
        check({tag, "_dz"}, 32'(div_zero), 32'(ez));
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, 32'(done), 32'd0);
        prev_q = eq;
        prev_r = er;
        prev_z = ez;
    endtask

    initial begin
        int n;
        int seen_done;
        n_tests  = 0;
        n_fail   = 0;
        prev_q   = '0;
        prev_r   = '0;
        prev_z   = 1'b0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", 32'(quotient), 32'd0);
        check("rst_r", 32'(remainder), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        rst = 1'b0;

        run_div("d1000_7", 20'd1000, 4'd7, 20'd142, 4'd6, 1'b0);
        run_div("rt_effff1", 20'hEFFF1, 4'd15, 20'h0FFFF, 4'd0, 1'b0);
        run_div("dz", 20'h12345, 4'd0, 20'hFFFFF, 4'h5, 1'b1);
        run_div("d20_3", 20'd20, 4'd3, 20'd6, 4'd2, 1'b0);

        // Back-to-back with start held high; a mid-busy operand change is ignored
        @(negedge clk);
        start    = 1'b1;
        dividend = 20'd50;
        divisor  = 4'd5;
        @(negedge clk);
        dividend = 20'd17;
        divisor  = 4'd4;
        repeat (9) @(negedge clk);
        dividend = 20'd999;
        divisor  = 4'd2;
        @(negedge clk);
        check("b2b_busy_mid", 32'(busy), 32'd1);
        dividend = 20'd17;
        divisor  = 4'd4;
        wait_done("b2b1", n);
        check("b2b1_q", 32'(quotient), 32'd10);
        check("b2b1_r", 32'(remainder), 32'd0);
        @(negedge clk);
        n = 1;
        while (!done && n < 60) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("b2b_gap", 32'(n), 32'd21);
        check("b2b2_q", 32'(quotient), 32'd4);
        check("b2b2_r", 32'(remainder), 32'd1);
        @(negedge clk);
        check("b2b_no_restart", 32'(busy), 32'd0);
        prev_q = 20'd4;

        // Reset in the middle of 99999/9
        @(negedge clk);
        start    = 1'b1;
        dividend = 20'd99999;
        divisor  = 4'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_q", 32'(quotient), 32'd0);
        check("mid_rst_r", 32'(remainder), 32'd0);
        check("mid_rst_dz", 32'(div_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        check("mid_rst_no_done", 32'(seen_done), 32'd0);
        prev_q = '0;

        run_div("d9_9", 20'd9, 4'd9, 20'd1, 4'd0, 1'b0);
        run_div("d0_1", 20'd0, 4'd1, 20'd0, 4'd0, 1'b0);
        run_div("dmax_1", 20'hFFFFF, 4'd1, 20'hFFFFF, 4'd0, 1'b0);
        run_div("dmax_15", 20'hFFFFF, 4'd15, 20'd69905, 4'd0, 1'b0);
        run_div("d14_15", 20'd14, 4'd15, 20'd0, 4'd14, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
